// File: rtl/shadow_bundle_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_pkg
//  Description : Shared widths and FSM state type for the Shadow-512 bundle
//                serializer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package shadow_pkg;

    localparam int SHADOW_STATE_W  = 512;
    localparam int SHADOW_BUNDLE_W = 128;
    localparam int SHADOW_NBUNDLES = 4;
    localparam int SHADOW_IDX_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shadow_state_e;

endpackage : shadow_pkg
`default_nettype wire

// File: rtl/shadow_bundle_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_bundle_serializer_if
//  Description : Capture-side and stream-side valid/ready bundle of the
//                serializer. "slave" is the serializer view, "master" is the
//                surrounding datapath view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shadow_bundle_serializer_if #(
    parameter int D = 2
) ();
    import shadow_pkg::*;

    logic [SHADOW_STATE_W*D-1:0]  in_bundles;
    logic                         in_valid;
    logic                         in_ready;
    logic [SHADOW_BUNDLE_W*D-1:0] out_bundle;
    logic [SHADOW_IDX_W-1:0]      out_idx;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_bundles, in_valid, out_ready,
        input  in_ready, out_bundle, out_idx, out_last, out_valid
    );

    modport slave (
        input  in_bundles, in_valid, out_ready,
        output in_ready, out_bundle, out_idx, out_last, out_valid
    );

endinterface : shadow_bundle_serializer_if
`default_nettype wire

// File: rtl/shadow_bundle_serializer_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_share_shreg
//  Description : One share's 512-bit state register: parallel load, shift
//                right by one bundle with zero fill, or clear. Only the low
//                bundle leaves the module, so share data never meets a mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_share_shreg
    import shadow_pkg::*;
(
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_load,
    input  wire logic                       i_shift,
    input  wire logic                       i_clear,
    input  wire logic [SHADOW_STATE_W-1:0]  i_d,
    output logic      [SHADOW_BUNDLE_W-1:0] o_bundle
);

    logic [SHADOW_STATE_W-1:0] r_q;

    // Load has priority so a back-to-back capture wins over the end-of-stream clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {{SHADOW_BUNDLE_W{1'b0}}, r_q[SHADOW_STATE_W-1:SHADOW_BUNDLE_W]};
        end
    end

    assign o_bundle = r_q[SHADOW_BUNDLE_W-1:0];

endmodule : shadow_share_shreg
`default_nettype wire

// File: rtl/shadow_bundle_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : shadow_bundle_serializer
//  Description : Captures a masked 512*D-bit state in bundle representation
//                and streams it as four 128*D-bit bundles (bundle 0 first)
//                over valid/ready.
//                Optional: define SHADOW_BSER_BACK2BACK_EN to let a new state
//                be captured on the last beat (4 cycles/state sustained).
//  Revision    : 1.0 - initial release
// ============================================================================
module shadow_bundle_serializer
    import shadow_pkg::*;
#(
    parameter int D = 2
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    shadow_bundle_serializer_if.slave   bus
);

    localparam logic [SHADOW_IDX_W-1:0] c_last_idx = SHADOW_IDX_W'(SHADOW_NBUNDLES - 1);

    shadow_state_e                r_state;
    shadow_state_e                w_state_nxt;
    logic [SHADOW_IDX_W-1:0]      r_idx;
    logic [SHADOW_IDX_W-1:0]      w_idx_nxt;
    logic                         w_load;
    logic                         w_shift;
    logic                         w_clear;
    logic                         w_beat;
    logic                         w_last_beat;
    logic                         w_in_ready;
    logic                         w_accept;
    logic [SHADOW_BUNDLE_W*D-1:0] w_out_bundle;

    assign w_beat      = (r_state == ST_SHIFT) && bus.out_ready;
    assign w_last_beat = w_beat && (r_idx == c_last_idx);

`ifdef SHADOW_BSER_BACK2BACK_EN
    // The final beat frees the registers in the same cycle, so capture may overlap it.
    assign w_in_ready = (r_state == ST_IDLE) || w_last_beat;
`else
    assign w_in_ready = (r_state == ST_IDLE);
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    // State and bundle index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state and share-register controls; a stall holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end else if (w_last_beat) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_clear     = 1'b1;
                end else if (w_beat) begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_shift     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_clear     = 1'b1;
            end
        endcase
    end

    // One independent register per share; only control is shared between them.
    for (genvar s = 0; s < D; s++) begin : g_share
        shadow_share_shreg u_shreg (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_load   (w_load),
            .i_shift  (w_shift),
            .i_clear  (w_clear),
            .i_d      (bus.in_bundles[SHADOW_STATE_W*s +: SHADOW_STATE_W]),
            .o_bundle (w_out_bundle[SHADOW_BUNDLE_W*s +: SHADOW_BUNDLE_W])
        );
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == ST_SHIFT);
    assign bus.out_idx    = r_idx;
    assign bus.out_last   = (r_state == ST_SHIFT) && (r_idx == c_last_idx);
    assign bus.out_bundle = w_out_bundle;

endmodule : shadow_bundle_serializer
`default_nettype wire

// File: tb/tb_shadow_bundle_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shadow_bundle_serializer
//  Description : Directed self-checking bench for shadow_bundle_serializer
//                (D=2) with a queue of expected beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shadow_bundle_serializer;
    import shadow_pkg::*;

    localparam int D  = 2;
    localparam int SW = SHADOW_STATE_W * D;
    localparam int BW = SHADOW_BUNDLE_W * D;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [1:0]    idx;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    shadow_bundle_serializer_if #(.D(D)) bus ();

    shadow_bundle_serializer #(.D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] make_state(input logic [31:0] base);
        logic [SW-1:0]  st;
        logic [31:0]    w;
        logic [127:0]   b0;
        st = '0;
        for (int b = 0; b < 4; b++) begin
            w  = base + 32'(b);
            b0 = {4{w}};
            st[128*b +: 128]       = b0;
            st[512 + 128*b +: 128] = ~b0;
        end
        return st;
    endfunction

    task automatic push_state(input logic [SW-1:0] st);
        beat_t e;
        for (int b = 0; b < 4; b++) begin
            e.data = {st[512 + 128*b +: 128], st[128*b +: 128]};
            e.idx  = 2'(b);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] st, input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_bundles = st;
        bus.in_valid   = 1'b1;
        push_state(st);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_valid_after_accept"}, bus.out_valid, 1'b1);
        chk({tag, "_idx_after_accept"}, bus.out_idx, 2'd0);
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating
    task automatic collect(input int n, input int mode, input string tag);
        int            beats;
        int            cyc;
        logic          stalled;
        logic [BW-1:0] pb;
        logic [1:0]    pi;
        logic          exp_rdy;
        beat_t         e;
        beats   = 0;
        cyc     = 0;
        stalled = 1'b0;
        pb      = '0;
        pi      = '0;
        while (beats < n && cyc < 64) begin
            bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            #1;
            if (stalled) begin
                chk({tag, "_stall_bundle"}, bus.out_bundle, pb);
                chk({tag, "_stall_idx"}, bus.out_idx, pi);
            end
            if (bus.out_valid && exp_q.size() > 0) begin
`ifdef SHADOW_BSER_BACK2BACK_EN
                exp_rdy = (exp_q[0].idx == 2'd3) && bus.out_ready;
`else
                exp_rdy = 1'b0;
`endif
                chk({tag, "_in_ready_busy"}, bus.in_ready, exp_rdy);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_beat"}, 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_bundle"}, bus.out_bundle, e.data);
                    chk({tag, "_idx"}, bus.out_idx, e.idx);
                    chk({tag, "_last"}, bus.out_last, (e.idx == 2'd3));
                end
                beats++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            pb      = bus.out_bundle;
            pi      = bus.out_idx;
            step();
            cyc++;
        end
        chk({tag, "_beat_count"}, 512'(beats), 512'(n));
    endtask

    initial begin
        logic [SW-1:0] s1, s2, s3, s4, s5, s6;
        s1 = make_state(32'h0000_00b0);
        s2 = make_state(32'h1111_2200);
        s3 = make_state(32'hcafe_0010);
        s4 = make_state(32'h5555_aa00);
        s5 = make_state(32'h0bad_f000);
        s6 = make_state(32'h7e57_0100);

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_bundles = '0;
        bus.out_ready  = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_out_bundle", bus.out_bundle, '0);
        rst_n = 1'b1;
        step();

        // Basic load and full-speed drain
        bus.out_ready = 1'b1;
        send(s1, "t1");
        collect(4, 0, "t1");
        chk("t1_idle_in_ready", bus.in_ready, 1'b1);
        chk("t1_idle_valid", bus.out_valid, 1'b0);
        chk("t1_idle_last", bus.out_last, 1'b0);
        chk("t1_idle_bundle", bus.out_bundle, '0);
        chk("t1_probe_s0", dut.g_share[0].u_shreg.r_q, '0);
        chk("t1_probe_s1", dut.g_share[1].u_shreg.r_q, '0);

        // Backpressure
        send(s6, "t2");
        collect(4, 1, "t2");
        chk("t2_idle_valid", bus.out_valid, 1'b0);

        // in_valid held with a different state during streaming
        chk("t3_in_ready", bus.in_ready, 1'b1);
        bus.in_bundles = s2;
        bus.in_valid   = 1'b1;
        push_state(s2);
        step();
        chk("t3_valid_after_accept", bus.out_valid, 1'b1);
        bus.in_bundles = s3;
        push_state(s3);
        collect(4, 0, "t3a");
`ifdef SHADOW_BSER_BACK2BACK_EN
        chk("t3_b2b_valid", bus.out_valid, 1'b1);
        chk("t3_b2b_idx", bus.out_idx, 2'd0);
`else
        chk("t3_idle_in_ready", bus.in_ready, 1'b1);
        chk("t3_idle_valid", bus.out_valid, 1'b0);
        step();
        chk("t3_second_valid", bus.out_valid, 1'b1);
        chk("t3_second_idx", bus.out_idx, 2'd0);
`endif
        bus.in_valid = 1'b0;
        collect(4, 0, "t3b");

        // Reset mid-stream after beat 1
        send(s4, "t4");
        collect(2, 0, "t4");
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", bus.out_valid, 1'b0);
        chk("t4_rst_bundle", bus.out_bundle, '0);
        chk("t4_rst_last", bus.out_last, 1'b0);
        chk("t4_rst_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("t4_no_beat_after_rst", bus.out_valid, 1'b0);
        send(s5, "t4n");
        collect(4, 1, "t4n");

`ifdef SHADOW_BSER_BACK2BACK_EN
        // Back-to-back: 8 beats in 8 consecutive cycles
        begin
            beat_t e;
            bus.out_ready  = 1'b1;
            chk("t5_in_ready", bus.in_ready, 1'b1);
            bus.in_bundles = s1;
            bus.in_valid   = 1'b1;
            push_state(s1);
            step();
            bus.in_bundles = s6;
            push_state(s6);
            for (int i = 0; i < 8; i++) begin
                e = exp_q.pop_front();
                chk("t5_valid", bus.out_valid, 1'b1);
                chk("t5_idx", bus.out_idx, e.idx);
                chk("t5_bundle", bus.out_bundle, e.data);
                chk("t5_last", bus.out_last, (e.idx == 2'd3));
                if (i == 7) bus.in_valid = 1'b0;
                step();
            end
            chk("t5_idle_valid", bus.out_valid, 1'b0);
        end
`endif

        chk("final_queue_empty", 512'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shadow_bundle_serializer
`default_nettype wire
